// File: rtl/cu_pkg.sv
// cu_pkg: control-word layout, state/pc_fs encodings and fixed control words
package cu_pkg;
    localparam int CW_W      = 33;
    localparam int CW_ALU_EN = 32;
    localparam int CW_ALU_BS = 31;
    localparam int CW_ALU_FS = 26;
    localparam int CW_RF_BEN = 25;
    localparam int CW_RF_SA  = 20;
    localparam int CW_RF_SB  = 15;
    localparam int CW_RF_DA  = 10;
    localparam int CW_RF_W   = 9;
    localparam int CW_RAM_EN = 8;
    localparam int CW_RAM_W  = 7;
    localparam int CW_PC_EN  = 6;
    localparam int CW_PC_FS  = 4;
    localparam int CW_PC_IS  = 3;
    localparam int CW_STATUS = 2;
    localparam int CW_NS     = 0;

    typedef enum logic [1:0] {S_FETCH = 2'b00, S_EX0 = 2'b01, S_EX1 = 2'b10, S_EX2 = 2'b11} state_t;
    typedef enum logic [1:0] {PC_HOLD = 2'b00, PC_INC = 2'b01, PC_LOAD = 2'b10, PC_REL = 2'b11} pc_fs_t;

    typedef struct packed {
        logic       alu_en;
        logic       alu_bs;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] rf_sa;
        logic [4:0] rf_sb;
        logic [4:0] rf_da;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_is;
        logic       status_ld;
        logic [1:0] next_state;
    } cw_t;

    localparam logic [CW_W-1:0] FETCH_CW = {1'b0, 1'b0, 5'b11111, 1'b0, 5'd31, 5'd31, 5'd31,
                                            1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01};
    localparam logic [CW_W-1:0] SAFE_CW  = {1'b0, 1'b0, 5'b11111, 26'd0};
endpackage

// File: rtl/cw_gate.sv
// cw_gate: masks the decoder control word during RAM stalls, timeouts and illegal opcodes
module cw_gate (
    input  logic [32:0] dec_cw,
    input  logic        illegal,
    input  logic        stall,
    input  logic        fault,
    output logic [32:0] cw
);
    import cu_pkg::*;
    cw_t c;
    always_comb begin
        c = cw_t'(dec_cw);
        if (stall || fault) begin
            c.rf_w      = 1'b0;
            c.ram_w     = 1'b0;
            c.status_ld = 1'b0;
            c.pc_fs     = PC_HOLD;
        end
        if (fault) c.pc_en = 1'b0;
        if (illegal) c = cw_t'(SAFE_CW);
    end
    assign cw = c;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute state sequencer with RAM stall gating and stall timeout
module control_sequencer #(
    parameter int STALL_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [63:0] databus,
    input  logic        mem_ready,
    input  logic [32:0] dec_cw,
    input  logic [63:0] dec_k,
    input  logic        dec_valid,
    output logic [31:0] ir,
    output logic [1:0]  state,
    output logic [32:0] cw,
    output logic [63:0] k,
    output logic        illegal_op,
    output logic        mem_fault
);
    import cu_pkg::*;
    localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
    state_t st;
    logic [CNT_W-1:0] cnt;
    logic fetch, illegal, stall, fault;
    logic [32:0] gated;
    cw_t fetch_cw;
    logic unused_bus;
    assign unused_bus = ^databus[63:32];
    assign fetch   = st == S_FETCH;
    assign illegal = !fetch && !dec_valid;
    assign stall   = fetch ? !mem_ready : dec_valid && dec_cw[CW_RAM_EN] && !mem_ready;
    assign fault   = stall && cnt == CNT_W'(STALL_TIMEOUT - 1);
    always_comb begin
        fetch_cw       = cw_t'(FETCH_CW);
        fetch_cw.pc_fs = mem_ready ? PC_INC : PC_HOLD;
    end
    cw_gate u_gate (
        .dec_cw (dec_cw),
        .illegal(illegal),
        .stall  (stall),
        .fault  (fault),
        .cw     (gated)
    );
    assign cw    = fetch ? fetch_cw : gated;
    assign k     = fetch ? '0 : dec_k;
    assign state = st;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st         <= S_FETCH;
            ir         <= '0;
            cnt        <= '0;
            illegal_op <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            illegal_op <= illegal;
            mem_fault  <= fault;
            cnt        <= (stall && !fault) ? cnt + 1'b1 : '0;
            if (fault || illegal) begin
                st <= S_FETCH;
            end else if (fetch) begin
                if (mem_ready) begin
                    ir <= databus[31:0];
                    st <= S_EX0;
                end
            end else if (!stall) begin
                st <= state_t'(dec_cw[CW_NS +: 2]);
            end
        end
    end
endmodule
